// File: rtl/video_pkg.sv
// Shared definitions for the video acquisition sequencer: FSM states and
// fixed timing constants.
package video_pkg;

  localparam int DATA_W       = 12;
  localparam int SETTLE_LEN   = 2;
  localparam int WAIT_LOW_MAX = 8;
  localparam int MIN_PERIOD   = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    SETTLE    = 3'd4,
    ACCUM     = 3'd5
  } state_t;

endpackage

// File: rtl/video_avg_acc.sv
// Sample accumulator: sums 2^AVG_LOG2 samples, emits the truncated mean and
// raises sticky window flags against the value being written.
module video_avg_acc #(
  parameter int DATA_W   = video_pkg::DATA_W,
  parameter int AVG_LOG2 = 2
) (
  input  logic              sclk_full,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] thr_hi,
  input  logic [DATA_W-1:0] thr_lo,
  input  logic              clr_flags,
  output logic [DATA_W-1:0] avg_data,
  output logic              avg_valid,
  output logic              over,
  output logic              under
);
  import video_pkg::*;

  localparam int AW = DATA_W + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);

  logic [AW-1:0]     acc;
  logic [AW-1:0]     sum;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] avg_next;
  logic              done;

  // Width AW holds 2^AVG_LOG2 full-scale samples, so the sum never wraps.
  assign sum      = acc + AW'(sample);
  assign avg_next = sum[AW-1:AVG_LOG2];
  assign done     = sample_en && (cnt == LAST);

  always_ff @(posedge sclk_full or negedge n_rst) begin
    if (!n_rst) begin
      acc       <= '0;
      cnt       <= '0;
      avg_data  <= '0;
      avg_valid <= 1'b0;
      over      <= 1'b0;
      under     <= 1'b0;
    end else begin
      avg_valid <= done;
      if (done) avg_data <= avg_next;
      if (clear || done) begin
        acc <= '0;
        cnt <= '0;
      end else if (sample_en) begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
      // A new threshold hit takes priority over a coincident clear.
      if (done && (avg_next > thr_hi)) over <= 1'b1;
      else if (clr_flags)              over <= 1'b0;
      if (done && (avg_next < thr_lo)) under <= 1'b1;
      else if (clr_flags)              under <= 1'b0;
    end
  end

endmodule

// File: rtl/video_sampler.sv
// Acquisition sequencer around video_spi: periodic start pulses, chip-select
// tracking with timeouts, and averaging of the captured samples.
module video_sampler #(
  parameter int DATA_W   = video_pkg::DATA_W,
  parameter int AVG_LOG2 = 2,
  parameter int PERIOD_W = 16,
  parameter int CS_TO    = 64
) (
  input  logic                sclk_full,
  input  logic                n_rst,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  input  logic [DATA_W-1:0]   thr_hi,
  input  logic [DATA_W-1:0]   thr_lo,
  input  logic                clr_flags,
  output logic                enable,
  input  logic                cs_n,
  input  logic [DATA_W-1:0]   parall_data,
  output logic [DATA_W-1:0]   avg_data,
  output logic                avg_valid,
  output logic                over,
  output logic                under,
  output logic                overrun,
  output logic                timeout,
  output logic [2:0]          fsm_state
);
  import video_pkg::*;

  localparam int TW = ($clog2(CS_TO + 1) > 4) ? $clog2(CS_TO + 1) : 4;

  state_t              state;
  state_t              next_state;
  logic [TW-1:0]       tcnt;
  logic [PERIOD_W-1:0] period_cnt;
  logic [PERIOD_W-1:0] eff_period;
  logic                pend;
  logic                tick;
  logic                set_timeout;

  assign eff_period = (period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : period;
  assign tick       = run && (period_cnt == eff_period - 1'b1);
  assign fsm_state  = state;

  // tcnt counts cycles in the current state; in WAIT_HIGH it counts low
  // cycles of cs_n including the one seen in WAIT_LOW.
  always_comb begin
    next_state  = state;
    set_timeout = 1'b0;
    case (state)
      IDLE:      if (run && (pend || tick)) next_state = START;
      START:     next_state = WAIT_LOW;
      WAIT_LOW:
        if (!cs_n) next_state = WAIT_HIGH;
        else if (tcnt == TW'(WAIT_LOW_MAX - 1)) begin
          next_state  = IDLE;
          set_timeout = 1'b1;
        end
      WAIT_HIGH:
        if (cs_n) next_state = SETTLE;
        else if (tcnt == TW'(CS_TO)) begin
          next_state  = IDLE;
          set_timeout = 1'b1;
        end
      SETTLE:    if (tcnt == TW'(SETTLE_LEN - 1)) next_state = ACCUM;
      ACCUM:     next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge sclk_full or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      tcnt       <= '0;
      period_cnt <= '0;
      pend       <= 1'b1;
      enable     <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state  <= next_state;
      enable <= (next_state == START);
      if (next_state != state) tcnt <= (next_state == WAIT_HIGH) ? TW'(1) : '0;
      else                     tcnt <= tcnt + 1'b1;
      if (!run)                period_cnt <= '0;
      else if (state == START) period_cnt <= PERIOD_W'(1);
      else                     period_cnt <= period_cnt + 1'b1;
      // pend holds at most one start: the first after run rises, or a missed tick.
      if (!run)                             pend <= 1'b1;
      else if (state == START)              pend <= 1'b0;
      else if (tick && (state != IDLE))     pend <= 1'b1;
      if (tick && (state != IDLE)) overrun <= 1'b1;
      else if (clr_flags)          overrun <= 1'b0;
      if (set_timeout)     timeout <= 1'b1;
      else if (clr_flags)  timeout <= 1'b0;
    end
  end

  video_avg_acc #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .sclk_full (sclk_full),
    .n_rst     (n_rst),
    .clear     ((state == IDLE) && !run),
    .sample_en (state == ACCUM),
    .sample    (parall_data),
    .thr_hi    (thr_hi),
    .thr_lo    (thr_lo),
    .clr_flags (clr_flags),
    .avg_data  (avg_data),
    .avg_valid (avg_valid),
    .over      (over),
    .under     (under)
  );

endmodule

// File: tb/tb_video_sampler.sv
// Bench for video_sampler: a video_spi-like responder, a start/average
// monitor and per-feature tests against a sum/4 reference model.
module tb_video_sampler;
  import video_pkg::*;

  localparam int DW = 12;

  logic          sclk_full = 1'b0;
  logic          n_rst = 1'b0;
  logic          run = 1'b0;
  logic          clr_flags = 1'b0;
  logic          cs_n = 1'b1;
  logic [15:0]   period = 16'd100;
  logic [DW-1:0] thr_hi = '1;
  logic [DW-1:0] thr_lo = '0;
  logic [DW-1:0] parall_data = '0;
  logic          enable, avg_valid, over, under, overrun, timeout;
  logic [DW-1:0] avg_data;
  logic [2:0]    fsm_state;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int start_q[$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] sample_q[$];
  int resp_delay = 1;
  int resp_len = 8;
  int resp_mode = 0;
  bit resp_rand = 1'b0;

  video_sampler dut (
    .sclk_full   (sclk_full),
    .n_rst       (n_rst),
    .run         (run),
    .period      (period),
    .thr_hi      (thr_hi),
    .thr_lo      (thr_lo),
    .clr_flags   (clr_flags),
    .enable      (enable),
    .cs_n        (cs_n),
    .parall_data (parall_data),
    .avg_data    (avg_data),
    .avg_valid   (avg_valid),
    .over        (over),
    .under       (under),
    .overrun     (overrun),
    .timeout     (timeout),
    .fsm_state   (fsm_state)
  );

  // clock / cycle index
  always #5 sclk_full = ~sclk_full;
  always @(posedge sclk_full) cyc <= cyc + 1;

  // monitor
  always @(negedge sclk_full) begin
    if (enable === 1'b1) start_q.push_back(cyc);
    if (avg_valid === 1'b1) got_q.push_back(avg_data);
  end

  // video_spi-like responder; resp_mode 1 never pulls cs_n low
  initial begin : responder
    int d;
    int l;
    forever begin
      @(negedge sclk_full);
      if (enable === 1'b1 && resp_mode == 0) begin
        d = resp_rand ? int'($urandom_range(0, 3)) : resp_delay;
        l = resp_rand ? int'($urandom_range(2, 12)) : resp_len;
        repeat (d) @(negedge sclk_full);
        cs_n = 1'b0;
        repeat (l) @(negedge sclk_full);
        parall_data = (sample_q.size() > 0) ? sample_q.pop_front() : DW'($urandom);
        cs_n = 1'b1;
      end
    end
  end

  // reference model: four samples per average, mean truncated
  task automatic push_group(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] c, input logic [DW-1:0] d);
    int s;
    sample_q.push_back(a);
    sample_q.push_back(b);
    sample_q.push_back(c);
    sample_q.push_back(d);
    s = int'(a) + int'(b) + int'(c) + int'(d);
    exp_q.push_back(DW'(s / 4));
  endtask

  task automatic wait_avgs(input int n, input int budget, input string tag);
    int t = 0;
    while (got_q.size() < n && t < budget) begin
      @(negedge sclk_full);
      t++;
    end
    n_checks++;
    if (got_q.size() < n) $display("FAIL %s: saw %0d averages, need %0d", tag, got_q.size(), n);
    else n_pass++;
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    int t = 0;
    while (start_q.size() < n && t < budget) begin
      @(negedge sclk_full);
      t++;
    end
    n_checks++;
    if (start_q.size() < n) $display("FAIL %s: saw %0d starts, need %0d", tag, start_q.size(), n);
    else n_pass++;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge sclk_full);
  endtask

  task automatic quiesce;
    int t = 0;
    run = 1'b0;
    while ((fsm_state !== 3'(IDLE) || cs_n !== 1'b1) && t < 300) begin
      @(negedge sclk_full);
      t++;
    end
    repeat (3) @(negedge sclk_full);
    clr_flags = 1'b1;
    @(negedge sclk_full);
    clr_flags = 1'b0;
    @(negedge sclk_full);
    start_q.delete();
    got_q.delete();
    exp_q.delete();
    sample_q.delete();
    resp_mode = 0; resp_rand = 1'b0; resp_delay = 1; resp_len = 8;
    thr_hi = '1; thr_lo = '0;
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    repeat (3) @(negedge sclk_full);
    n_checks++; if (enable !== 1'b0) $display("FAIL rst_enable: got %b want 0", enable); else n_pass++;
    n_checks++; if (avg_valid !== 1'b0) $display("FAIL rst_avg_valid: got %b want 0", avg_valid); else n_pass++;
    n_checks++; if (avg_data !== '0) $display("FAIL rst_avg_data: got %h want 0", avg_data); else n_pass++;
    n_checks++; if ({over, under, overrun, timeout} !== 4'b0) $display("FAIL rst_flags: got %b want 0000", {over, under, overrun, timeout}); else n_pass++;
    n_checks++; if (fsm_state !== 3'(IDLE)) $display("FAIL rst_state: got %0d want %0d", fsm_state, 3'(IDLE)); else n_pass++;
    n_rst = 1'b1;
    repeat (5) @(negedge sclk_full);
    n_checks++; if (start_q.size() != 0) $display("FAIL idle_no_start: got %0d starts want 0", start_q.size()); else n_pass++;
  endtask

  task automatic test_constant;
    int t_run;
    quiesce();
    period = 16'd100;
    push_group(12'h400, 12'h400, 12'h400, 12'h400);
    run = 1'b1;
    t_run = cyc;
    wait_avgs(1, 600, "const_wait");
    run = 1'b0;
    repeat (20) @(negedge sclk_full);
    n_checks++; if (got_q.size() != 1) $display("FAIL const_count: got %0d averages want 1", got_q.size()); else n_pass++;
    n_checks++; if (got_q.size() > 0 && got_q[0] !== exp_q[0]) $display("FAIL const_avg: got %h want %h", got_q[0], exp_q[0]); else n_pass++;
    n_checks++; if (start_q.size() != 4) $display("FAIL const_starts: got %0d want 4", start_q.size()); else n_pass++;
    n_checks++; if (start_q.size() > 0 && start_q[0] != t_run + 1) $display("FAIL first_start: got cycle %0d want %0d", start_q[0], t_run + 1); else n_pass++;
    for (int i = 1; i < start_q.size(); i++) begin
      n_checks++;
      if (start_q[i] - start_q[i-1] != 100) $display("FAIL const_spacing%0d: got %0d want 100", i, start_q[i] - start_q[i-1]);
      else n_pass++;
    end
  endtask

  task automatic test_truncate;
    quiesce();
    period = 16'd40;
    push_group(12'd1, 12'd2, 12'd2, 12'd2);
    run = 1'b1;
    wait_avgs(1, 400, "trunc_wait");
    run = 1'b0;
    n_checks++; if (got_q.size() > 0 && got_q[0] !== exp_q[0]) $display("FAIL trunc_avg: got %h want %h", got_q[0], exp_q[0]); else n_pass++;
  endtask

  task automatic test_random;
    logic [DW-1:0] s[4];
    logic e_over;
    logic e_under;
    quiesce();
    period = 16'd40;
    resp_rand = 1'b1;
    thr_hi = DW'($urandom_range(12'h600, 12'hfff));
    thr_lo = DW'($urandom_range(0, 12'h600));
    for (int g = 0; g < 8; g++) begin
      for (int k = 0; k < 4; k++)
        s[k] = (g == 6) ? 12'hfff : (g == 7) ? 12'h000 : DW'($urandom);
      push_group(s[0], s[1], s[2], s[3]);
    end
    e_over = 1'b0;
    e_under = 1'b0;
    foreach (exp_q[i]) begin
      if (exp_q[i] > thr_hi) e_over = 1'b1;
      if (exp_q[i] < thr_lo) e_under = 1'b1;
    end
    run = 1'b1;
    wait_avgs(8, 8 * 4 * 40 + 300, "rand_wait");
    run = 1'b0;
    for (int i = 0; i < got_q.size() && i < 8; i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL rand_avg%0d: got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (over !== e_over) $display("FAIL rand_over: got %b want %b", over, e_over); else n_pass++;
    n_checks++; if (under !== e_under) $display("FAIL rand_under: got %b want %b", under, e_under); else n_pass++;
  endtask

  task automatic test_clamp;
    quiesce();
    period = 16'd10;
    run = 1'b1;
    wait_starts(3, 200, "clamp_wait");
    run = 1'b0;
    for (int i = 1; i < start_q.size() && i < 3; i++) begin
      n_checks++;
      if (start_q[i] - start_q[i-1] != 32) $display("FAIL clamp_spacing%0d: got %0d want 32", i, start_q[i] - start_q[i-1]);
      else n_pass++;
    end
    n_checks++; if (overrun !== 1'b0) $display("FAIL clamp_overrun: got %b want 0", overrun); else n_pass++;
  endtask

  task automatic test_overrun;
    int sp;
    quiesce();
    period = 16'd30;
    resp_delay = 1;
    resp_len = 30;
    run = 1'b1;
    wait_starts(2, 200, "ovr_wait");
    run = 1'b0;
    sp = (start_q.size() >= 2) ? start_q[1] - start_q[0] : 0;
    n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun); else n_pass++;
    n_checks++; if (timeout !== 1'b0) $display("FAIL ovr_no_timeout: got %b want 0", timeout); else n_pass++;
    n_checks++; if (sp < 33 || sp > 40) $display("FAIL ovr_spacing: got %0d want 33..40", sp); else n_pass++;
  endtask

  task automatic test_timeout_high;
    int s0;
    quiesce();
    period = 16'd100;
    resp_mode = 1;
    run = 1'b1;
    wait_starts(1, 20, "toh_wait");
    s0 = (start_q.size() > 0) ? start_q[0] : cyc;
    wait_cyc(s0 + 6);
    n_checks++; if (timeout !== 1'b0) $display("FAIL toh_early: got %b want 0", timeout); else n_pass++;
    wait_cyc(s0 + 10);
    n_checks++; if (timeout !== 1'b1) $display("FAIL toh_flag: got %b want 1", timeout); else n_pass++;
    n_checks++; if (fsm_state !== 3'(IDLE)) $display("FAIL toh_state: got %0d want %0d", fsm_state, 3'(IDLE)); else n_pass++;
    wait_starts(2, 200, "toh_wait2");
    run = 1'b0;
    n_checks++; if (start_q.size() >= 2 && start_q[1] - s0 != 100) $display("FAIL toh_next_start: got %0d want 100", start_q[1] - s0); else n_pass++;
    n_checks++; if (got_q.size() != 0) $display("FAIL toh_no_avg: got %0d averages want 0", got_q.size()); else n_pass++;
  endtask

  task automatic test_timeout_low;
    int s0;
    quiesce();
    period = 16'd100;
    resp_delay = 0;
    resp_len = 70;
    run = 1'b1;
    wait_starts(1, 20, "tol_wait");
    s0 = (start_q.size() > 0) ? start_q[0] : cyc;
    wait_cyc(s0 + 40);
    n_checks++; if (timeout !== 1'b0) $display("FAIL tol_early: got %b want 0", timeout); else n_pass++;
    n_checks++; if (fsm_state !== 3'(WAIT_HIGH)) $display("FAIL tol_state: got %0d want %0d", fsm_state, 3'(WAIT_HIGH)); else n_pass++;
    wait_cyc(s0 + 75);
    n_checks++; if (timeout !== 1'b1) $display("FAIL tol_flag: got %b want 1", timeout); else n_pass++;
    wait_cyc(s0 + 80);
    run = 1'b0;
    n_checks++; if (got_q.size() != 0) $display("FAIL tol_no_avg: got %0d averages want 0", got_q.size()); else n_pass++;
  endtask

  task automatic test_over_clear;
    int accs = 0;
    int t = 0;
    quiesce();
    period = 16'd40;
    thr_hi = 12'h800;
    push_group(12'h900, 12'h900, 12'h900, 12'h900);
    push_group(12'h900, 12'h900, 12'h900, 12'h900);
    run = 1'b1;
    wait_avgs(1, 400, "oc_wait");
    n_checks++; if (got_q.size() > 0 && got_q[0] !== exp_q[0]) $display("FAIL oc_avg: got %h want %h", got_q[0], exp_q[0]); else n_pass++;
    n_checks++; if (over !== (exp_q[0] > thr_hi)) $display("FAIL oc_over: got %b want %b", over, exp_q[0] > thr_hi); else n_pass++;
    while (accs < 4 && t < 400) begin
      @(negedge sclk_full);
      if (fsm_state === 3'(ACCUM)) accs++;
      t++;
    end
    n_checks++; if (accs != 4) $display("FAIL oc_align: got %0d accumulates want 4", accs); else n_pass++;
    clr_flags = 1'b1;
    @(negedge sclk_full);
    clr_flags = 1'b0;
    run = 1'b0;
    n_checks++; if (avg_valid !== 1'b1) $display("FAIL oc_valid: got %b want 1", avg_valid); else n_pass++;
    n_checks++; if (over !== 1'b1) $display("FAIL oc_set_wins: got %b want 1", over); else n_pass++;
    clr_flags = 1'b1;
    @(negedge sclk_full);
    clr_flags = 1'b0;
    @(negedge sclk_full);
    n_checks++; if (over !== 1'b0) $display("FAIL oc_clear: got %b want 0", over); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int accs = 0;
    int t = 0;
    logic [DW-1:0] s[4];
    quiesce();
    period = 16'd40;
    push_group(12'h100, 12'h200, 12'h300, 12'hfff);
    run = 1'b1;
    while ((accs < 2 || fsm_state !== 3'(WAIT_HIGH)) && t < 400) begin
      @(negedge sclk_full);
      if (fsm_state === 3'(ACCUM)) accs++;
      t++;
    end
    n_checks++; if (fsm_state !== 3'(WAIT_HIGH)) $display("FAIL rm_reach: got state %0d want %0d", fsm_state, 3'(WAIT_HIGH)); else n_pass++;
    n_rst = 1'b0;
    #1;
    n_checks++; if (avg_data !== '0) $display("FAIL rm_avg_data: got %h want 0", avg_data); else n_pass++;
    n_checks++; if ({enable, avg_valid, over, under, overrun, timeout} !== 6'b0) $display("FAIL rm_outputs: got %b want 000000", {enable, avg_valid, over, under, overrun, timeout}); else n_pass++;
    n_checks++; if (fsm_state !== 3'(IDLE)) $display("FAIL rm_state: got %0d want %0d", fsm_state, 3'(IDLE)); else n_pass++;
    t = 0;
    while (cs_n !== 1'b1 && t < 100) begin
      @(negedge sclk_full);
      t++;
    end
    repeat (2) @(negedge sclk_full);
    sample_q.delete();
    exp_q.delete();
    got_q.delete();
    for (int k = 0; k < 4; k++) s[k] = DW'($urandom);
    push_group(s[0], s[1], s[2], s[3]);
    n_rst = 1'b1;
    wait_avgs(1, 400, "rm_wait");
    run = 1'b0;
    n_checks++; if (got_q.size() > 0 && got_q[0] !== exp_q[0]) $display("FAIL rm_fresh_avg: got %h want %h", got_q[0], exp_q[0]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_constant();
    test_truncate();
    test_random();
    test_clamp();
    test_overrun();
    test_timeout_high();
    test_timeout_low();
    test_over_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
